// File: rtl/memory_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter_if
//  Description : Requester and memory-bus signal bundle for memory_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       ack0;
    logic       ack1;
    logic       err;
    logic [7:0] rdata;
    logic       owner;
    logic       mem_read_enable;
    logic       mem_write_enable;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic [7:0] mem_out;

    // Arbiter side
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
        output ack0, ack1, err, rdata, owner,
               mem_read_enable, mem_write_enable, mem_address, mem_data
    );

    // Requesters plus the memory block
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
        input  ack0, ack1, err, rdata, owner,
               mem_read_enable, mem_write_enable, mem_address, mem_data
    );
endinterface
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : memory_arbiter
//  Description : Two-port arbiter/sequencer for the register-file memory.
//                Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration,
//                otherwise port 0 has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int DEPTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    memory_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;
    localparam logic [8:0] c_DEPTH  = 9'(DEPTH);

    logic [1:0] r_state;
    logic       r_owner;
    logic       r_we;
    logic       r_oor;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_err;
    logic       r_re;
    logic       r_wr;
    logic [7:0] r_rdata;
    logic [7:0] r_addr;
    logic [7:0] r_data;

    logic       w_any_req;
    logic       w_grant;
    logic       w_sel_we;
    logic       w_sel_oor;
    logic [7:0] w_sel_addr;
    logic [7:0] w_sel_wdata;

    assign w_any_req = bus.req0 | bus.req1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Port that wins the next simultaneous request
    logic r_rr_prio;

    assign w_grant = (bus.req0 && bus.req1) ? r_rr_prio : bus.req1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_prio <= 1'b0;
        end else if (r_state == c_IDLE && w_any_req) begin
            r_rr_prio <= ~w_grant;
        end
    end
`else
    assign w_grant = bus.req1 & ~bus.req0;
`endif

    assign w_sel_we    = w_grant ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_grant ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_grant ? bus.wdata1 : bus.wdata0;
    assign w_sel_oor   = ({1'b0, w_sel_addr} >= c_DEPTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err   <= 1'b0;
            r_re    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= 8'h00;
            r_addr  <= 8'h00;
            r_data  <= 8'h00;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant;
                        r_we    <= w_sel_we;
                        r_oor   <= w_sel_oor;
                        r_addr  <= w_sel_addr;
                        r_data  <= w_sel_wdata;
                        // Enables are registered here so they are high in ACCESS
                        r_wr    <= w_sel_we & ~w_sel_oor;
                        r_re    <= ~w_sel_we & ~w_sel_oor;
                        r_state <= c_ACCESS;
                    end
                end
                c_ACCESS: begin
                    r_wr   <= 1'b0;
                    r_re   <= 1'b0;
                    if (!r_we) begin
                        r_rdata <= r_oor ? 8'h00 : bus.mem_out;
                    end
                    r_ack0  <= ~r_owner;
                    r_ack1  <= r_owner;
                    r_err   <= r_oor;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_wr    <= 1'b0;
                    r_re    <= 1'b0;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0             = r_ack0;
    assign bus.ack1             = r_ack1;
    assign bus.err              = r_err;
    assign bus.rdata            = r_rdata;
    assign bus.owner            = r_owner;
    assign bus.mem_read_enable  = r_re;
    assign bus.mem_write_enable = r_wr;
    assign bus.mem_address      = r_addr;
    assign bus.mem_data         = r_data;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_arbiter
//  Description : Self-checking bench for memory_arbiter with a memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;
    int   total = 0;
    int   bad = 0;

    memory_arbiter_if bus();

    memory_arbiter #(.DEPTH(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Environment memory: combinational read, write on rising edge
    logic [7:0] mem [0:8];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 9; i++) mem[i] <= 8'h80 + 8'(i);
        end else if (bus.mem_write_enable && bus.mem_address < 8'd9) begin
            mem[bus.mem_address[3:0]] <= bus.mem_data;
        end
    end
    always_comb begin
        bus.mem_out = 8'hEE;
        if (bus.mem_address < 8'd9) bus.mem_out = mem[bus.mem_address[3:0]];
    end

    // Reference model: transactions applied in grant order
    logic [7:0] refmem [0:8];
    logic [7:0] ref_rdata;
    int         last_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        ref_rdata  = 8'h00;
        last_grant = 1;
    endtask

    task automatic model_apply(input int port, input bit we, input logic [7:0] addr,
                               input logic [7:0] wdata, output logic [7:0] er, output bit ee);
        ee = (addr >= 8'd9);
        if (we && !ee) refmem[addr[3:0]] = wdata;
        if (!we) ref_rdata = ee ? 8'h00 : refmem[addr[3:0]];
        er = ref_rdata;
        last_grant = port;
    endtask

    function automatic int tie_winner();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return (last_grant == 0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    // Protocol watchdog on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_read_enable || bus.mem_write_enable) begin
                total++;
                if ((bus.mem_read_enable && bus.mem_write_enable) || bus.mem_address >= 8'd9) begin
                    bad++;
                    $display("FAIL enables: re=%0b we=%0b addr=%0h required one enable, addr<9",
                             bus.mem_read_enable, bus.mem_write_enable, bus.mem_address);
                end
            end
            if (bus.ack0 || bus.ack1) begin
                total++;
                if (bus.ack0 && bus.ack1) begin
                    bad++;
                    $display("FAIL acks: ack0=1 ack1=1 required at most one");
                end
            end
        end
    end

    task automatic drive(input int port, input bit on, input bit we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            bus.req0 = on; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end else begin
            bus.req1 = on; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    task automatic run_txn(input int port, input bit we, input logic [7:0] addr,
                           input logic [7:0] wdata, input string name,
                           input bit use_exp, input logic [7:0] t_rdata, input bit t_err);
        logic [7:0] er;
        bit ee;
        int lat, wen, ren;
        bit done, inr;
        model_apply(port, we, addr, wdata, er, ee);
        if (use_exp) begin
            er = t_rdata;
            ee = t_err;
        end
        inr = (addr < 8'd9);
        @(posedge clk); #1;
        drive(port, 1'b1, we, addr, wdata);
        lat = 0; wen = 0; ren = 0; done = 0;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (bus.mem_write_enable) begin
                wen++;
                check({name, "_waddr"}, 32'(bus.mem_address), 32'(addr));
                check({name, "_wdata"}, 32'(bus.mem_data), 32'(wdata));
            end
            if (bus.mem_read_enable) begin
                ren++;
                check({name, "_raddr"}, 32'(bus.mem_address), 32'(addr));
            end
            if (bus.ack0 || bus.ack1) begin
                done = 1;
                check({name, "_ackport"}, 32'(bus.ack1), 32'(port));
                check({name, "_owner"}, 32'(bus.owner), 32'(port));
                check({name, "_latency"}, 32'(lat), 32'd2);
                check({name, "_err"}, 32'(bus.err), 32'(ee));
                check({name, "_rdata"}, 32'(bus.rdata), 32'(er));
            end
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_wen_cycles"}, 32'(wen), (we && inr) ? 32'd1 : 32'd0);
        check({name, "_ren_cycles"}, 32'(ren), (!we && inr) ? 32'd1 : 32'd0);
        drive(port, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    // Both ports request together and keep requesting for k grants
    task automatic run_tie(input bit we0, input logic [7:0] a0, input logic [7:0] d0,
                           input bit we1, input logic [7:0] a1, input logic [7:0] d1,
                           input int k, input string name);
        logic [7:0] er;
        bit ee;
        int cyc, got, w;
        @(posedge clk); #1;
        drive(0, 1'b1, we0, a0, d0);
        drive(1, 1'b1, we1, a1, d1);
        cyc = 0; got = 0;
        while (got < k && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.ack0 || bus.ack1) begin
                w = tie_winner();
                if (w == 0) model_apply(0, we0, a0, d0, er, ee);
                else        model_apply(1, we1, a1, d1, er, ee);
                check({name, "_winner"}, 32'(bus.ack1), 32'(w));
                check({name, "_owner"}, 32'(bus.owner), 32'(w));
                check({name, "_spacing"}, 32'(cyc), 32'(2 + 3 * got));
                check({name, "_err"}, 32'(bus.err), 32'(ee));
                check({name, "_rdata"}, 32'(bus.rdata), 32'(er));
                got++;
            end
        end
        if (got < k) check({name, "_timeout"}, 32'(got), 32'(k));
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    typedef struct {
        int         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        bit         exp_err;
    } vec_t;

    vec_t vt [15];

    initial begin
        vt[0]  = '{0, 1'b1, 8'h03, 8'hA5, 8'h00, 1'b0};
        vt[1]  = '{0, 1'b0, 8'h03, 8'h00, 8'hA5, 1'b0};
        vt[2]  = '{1, 1'b1, 8'h09, 8'hFF, 8'hA5, 1'b1};
        vt[3]  = '{1, 1'b0, 8'h09, 8'h00, 8'h00, 1'b1};
        vt[4]  = '{1, 1'b0, 8'h08, 8'h00, 8'h88, 1'b0};
        vt[5]  = '{0, 1'b1, 8'h08, 8'h5A, 8'h88, 1'b0};
        vt[6]  = '{1, 1'b0, 8'h08, 8'h00, 8'h5A, 1'b0};
        vt[7]  = '{0, 1'b1, 8'h02, 8'h11, 8'h5A, 1'b0};
        vt[8]  = '{0, 1'b0, 8'h02, 8'h00, 8'h11, 1'b0};
        vt[9]  = '{1, 1'b1, 8'h04, 8'h22, 8'h11, 1'b0};
        vt[10] = '{0, 1'b0, 8'h04, 8'h00, 8'h22, 1'b0};
        vt[11] = '{1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};
        vt[12] = '{0, 1'b0, 8'h00, 8'h00, 8'h80, 1'b0};
        vt[13] = '{1, 1'b1, 8'h00, 8'h7E, 8'h80, 1'b0};
        vt[14] = '{0, 1'b0, 8'h00, 8'h00, 8'h7E, 1'b0};

        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        for (int i = 0; i < 9; i++) refmem[i] = 8'h80 + 8'(i);
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_ren", 32'(bus.mem_read_enable), 32'd0);
        check("rst_wen", 32'(bus.mem_write_enable), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_data", 32'(bus.mem_data), 32'd0);
        reset = 0;
        mem_init = 0;

        for (int i = 0; i < 15; i++) begin
            run_txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata,
                    $sformatf("vec%0d", i), 1'b1, vt[i].exp_rdata, vt[i].exp_err);
        end

        // Reset during the ACCESS cycle of a read
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 8'h02, 8'h00);
        @(posedge clk); #1;
        check("midop_ren", 32'(bus.mem_read_enable), 32'd1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        model_reset();
        check("midop_ack0", 32'(bus.ack0), 32'd0);
        check("midop_ack1", 32'(bus.ack1), 32'd0);
        check("midop_err", 32'(bus.err), 32'd0);
        check("midop_en", 32'({bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
        check("midop_rdata", 32'(bus.rdata), 32'd0);
        check("midop_owner", 32'(bus.owner), 32'd0);
        check("midop_addr", 32'(bus.mem_address), 32'd0);
        @(posedge clk); #1;
        check("midop_noack", 32'({bus.ack0, bus.ack1}), 32'd0);
        run_txn(0, 1'b0, 8'h02, 8'h00, "post_rst", 1'b0, 8'h00, 1'b0);

        // Simultaneous read/write of address 1, three grants
        run_tie(1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 8'h3C, 3, "tie");

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_tie(1'($urandom), 8'($urandom_range(0, 11)), 8'($urandom),
                        1'($urandom), 8'($urandom_range(0, 11)), 8'($urandom),
                        int'($urandom_range(1, 3)), $sformatf("rtie%0d", n));
            end else begin
                run_txn(int'($urandom_range(0, 1)), 1'($urandom),
                        8'($urandom_range(0, 11)), 8'($urandom),
                        $sformatf("rnd%0d", n), 1'b0, 8'h00, 1'b0);
            end
        end

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
# memory_arbiter

Two-port arbiter and sequencer for the 9-byte register-file memory of the 8-bit computer. It accepts byte read/write requests from two requesters, the control unit on port 0 and the program loader on port 1. It serialises them onto the memory's single enable/address/data bus and returns read data with a one-cycle acknowledge. It sits between the requesters and the memory block, and is the only driver of the memory's read_enable, write_enable, address and data inputs.

## Interface
- DEPTH, 9, number of implemented memory locations (valid addresses 0 to DEPTH-1)
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request from port 0 / port 1; held high until ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  8  byte address; stable while req high
- wdata0 / wdata1  in  8  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse to the owning port
- err  out  1  high with ack when the address was >= DEPTH
- rdata  out  8  last read result, shared by both ports
- owner  out  1  port currently or last granted
- mem_read_enable  out  1  to memory read_enable
- mem_write_enable  out  1  to memory write_enable
- mem_address  out  8  to memory address
- mem_data  out  8  to memory data (write data)
- mem_out  in  8  memory out bus (read data)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, pick a winner, latch its we, addr and wdata, set owner, and go to ACCESS. If no req is high, stay in IDLE.
- ACCESS, in-range address: drive mem_address and mem_data from the latched values. Assert exactly one of mem_write_enable or mem_read_enable according to the latched we. Reads capture mem_out into rdata at the end of the cycle. Go to RESP.
- ACCESS, address >= DEPTH: no enable is asserted, the write is dropped, and a read loads rdata with 8'h00. Go to RESP.
- RESP: pulse ack of owner. err is high in this cycle if the address was out of range. Enables are low. Go to IDLE. req inputs are ignored in RESP.
- Arbitration is selected by the Configuration macro. In both modes a single requester is always granted.
- Requesters deassert req on the edge that ends the ack cycle. If req is still high in IDLE, it is treated as a new transaction.
- rdata holds its value across write transactions and idle periods, and changes only at the end of a read ACCESS.
- Reset: state IDLE, owner 0, round-robin pointer set so port 0 wins the first tie. ack0, ack1, err, mem_read_enable and mem_write_enable are 0. rdata, mem_address and mem_data are 8'h00.
- Reset mid-transaction aborts it: no ack is issued. If reset is high during ACCESS, the memory's own reset takes precedence over the write.

## Timing
- All outputs are registered.
- req is sampled high in cycle t (IDLE). Memory enables are high in t+1 (ACCESS). ack is high in t+2 (RESP), and rdata is valid from t+2.
- Back-to-back throughput is one transaction per 3 cycles. The earliest next grant is sampled in the cycle after RESP.
- Memory enables are high for exactly one cycle per in-range transaction and are never both high.
- ack0 and ack1 are never high in the same cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. On simultaneous requests, the port not granted last wins, and the pointer updates on each grant.
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority. Port 0 always wins simultaneous requests, and port 1 can starve. No pointer register is present.

## Test plan
- Single write then read: req0 writes 8'hA5 to addr 3, then req0 reads addr 3. Required: mem_write_enable high one cycle with address 3 and data A5; ack0 two cycles after each req; rdata = A5 in the second ack cycle.
- Simultaneous requests, round-robin build: req0 reads addr 1 and req1 writes 8'h3C to addr 1, three times back-to-back. Required: grant order 0,1,0. Fixed-priority build: grant order 0,0,0 while req1 waits.
- Out-of-range: req1 writes 8'hFF to addr 8'h09, then reads addr 9. Required: no memory enable asserted; ack1 with err=1 both times; rdata = 00 after the read; location 8 unchanged.
- Boundary address: write 8'h5A to addr 8, then read addr 8. Required: rdata = 5A, err = 0.
- rdata hold: read addr 2 (containing 8'h11), then write 8'h22 to addr 4. Required: rdata stays 11 through the write's ack.
- Reset mid-op: assert reset in the ACCESS cycle of a read. Required: no ack; next cycle is IDLE with all outputs 0 and rdata 00; a following req0 is served normally with 2-cycle latency.
